// File: rtl/pe_row_mac.sv
// rtl/pe_row_mac.sv - row of shift-chain PEs with gated taps, serial weights and pipelined saturating MAC
module pe_row_mac #(
    parameter int DATA_W = 8,
    parameter int NUM_PE = 3,
    parameter int ACC_W  = 20,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_load,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic                     start,
    input  logic [LEN_W-1:0]         acc_len,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic [NUM_PE-1:0]        enable,
    output logic signed [DATA_W-1:0] data_o,
    output logic [NUM_PE*DATA_W-1:0] tap_o,
    output logic signed [ACC_W-1:0]  sum_o,
    output logic                     sum_valid,
    output logic                     sat,
    output logic                     busy
);

    localparam int PROD_W = 2*DATA_W + $clog2(NUM_PE);
    localparam int EXT_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic signed [DATA_W-1:0] stage   [NUM_PE];
    logic signed [DATA_W-1:0] w       [NUM_PE];
    logic signed [DATA_W-1:0] lane_in [NUM_PE];
    logic signed [DATA_W-1:0] tap     [NUM_PE];
    logic [LEN_W-1:0]         len_r, count;
    logic signed [PROD_W-1:0] prod_sum, psum;
    logic                     pv, plast;
    logic signed [ACC_W-1:0]  acc, acc_next;
    logic signed [EXT_W-1:0]  acc_sum;
    logic                     sat_r, clip;
    logic                     accept_start, run_beat, last_beat;

    genvar gk;
    for (gk = 0; gk < NUM_PE; gk++) begin : g_lane
        if (gk == 0) begin : g_head
            assign lane_in[gk] = data_i;
        end else begin : g_body
            assign lane_in[gk] = stage[gk-1];
        end
        assign tap[gk] = enable[gk] ? lane_in[gk] : '0;
        assign tap_o[gk*DATA_W +: DATA_W] = tap[gk];
    end

    assign data_o = stage[NUM_PE-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_PE; k++) stage[k] <= '0;
        end else if (valid) begin
            stage[0] <= data_i;
            for (int k = 1; k < NUM_PE; k++) stage[k] <= stage[k-1];
        end
    end

    // Weights are frozen for the duration of a job so a running sum stays consistent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_PE; k++) w[k] <= '0;
        end else if (w_load && !busy) begin
            w[0] <= w_data;
            for (int k = 1; k < NUM_PE; k++) w[k] <= w[k-1];
        end
    end

    always_comb begin
        prod_sum = '0;
        for (int k = 0; k < NUM_PE; k++)
            prod_sum = prod_sum + PROD_W'(tap[k]) * PROD_W'(w[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_beat) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        accept_start = (state == IDLE) && start;
        run_beat     = (state == RUN) && valid;
        last_beat    = run_beat && (count == len_r - LEN_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r <= '0;
            count <= '0;
        end else if (accept_start) begin
            len_r <= (acc_len == '0) ? LEN_W'(1) : acc_len;
            count <= '0;
        end else if (run_beat) begin
            count <= count + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psum  <= '0;
            pv    <= 1'b0;
            plast <= 1'b0;
        end else begin
            psum  <= run_beat ? prod_sum : psum;
            pv    <= run_beat;
            plast <= last_beat;
        end
    end

    always_comb begin
        acc_sum  = EXT_W'(acc) + EXT_W'(psum);
        clip     = 1'b0;
        acc_next = ACC_W'(acc_sum);
        if (acc_sum > SAT_MAX) begin
            acc_next = ACC_MAX;
            clip     = 1'b1;
        end else if (acc_sum < SAT_MIN) begin
            acc_next = ACC_MIN;
            clip     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sat_r     <= 1'b0;
            sum_o     <= '0;
            sat       <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (accept_start) begin
                acc   <= '0;
                sat_r <= 1'b0;
            end else if (pv) begin
                acc   <= acc_next;
                sat_r <= sat_r | clip;
                if (plast) begin
                    sum_o     <= acc_next;
                    sat       <= sat_r | clip;
                    sum_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_row_mac.sv
// tb/tb_pe_row_mac.sv - self-checking bench for pe_row_mac against a job-level reference model
module tb_pe_row_mac;

    localparam int DW = 8;
    localparam int NP = 3;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 w_load = 1'b0;
    logic signed [DW-1:0] w_data = '0;
    logic                 start  = 1'b0;
    logic [LW-1:0]        acc_len = '0;
    logic                 valid  = 1'b0;
    logic signed [DW-1:0] data_i = '0;
    logic [NP-1:0]        enable = '0;

    logic signed [DW-1:0] data_a, data_b;
    logic [NP*DW-1:0]     tap_a, tap_b;
    logic signed [19:0]   sum_a;
    logic signed [15:0]   sum_b;
    logic                 sv_a, sv_b, sat_a, sat_b, busy_a, busy_b;

    pe_row_mac #(.DATA_W(DW), .NUM_PE(NP), .ACC_W(20), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .w_load(w_load), .w_data(w_data), .start(start),
        .acc_len(acc_len), .valid(valid), .data_i(data_i), .enable(enable),
        .data_o(data_a), .tap_o(tap_a), .sum_o(sum_a), .sum_valid(sv_a), .sat(sat_a), .busy(busy_a));

    pe_row_mac #(.DATA_W(DW), .NUM_PE(NP), .ACC_W(16), .LEN_W(LW)) dut16 (
        .clk(clk), .rst(rst), .w_load(w_load), .w_data(w_data), .start(start),
        .acc_len(acc_len), .valid(valid), .data_i(data_i), .enable(enable),
        .data_o(data_b), .tap_o(tap_b), .sum_o(sum_b), .sum_valid(sv_b), .sat(sat_b), .busy(busy_b));

    int tests = 0;
    int fails = 0;

    // Reference model: chain and weights as plain arrays, a job as the list of its beat sums.
    int     mchain [NP];
    int     mw     [NP];
    bit     running, pend;
    int     mlen;
    longint prods [$];
    longint msum20, msum16, nsum20, nsum16;
    bit     msat20, msat16, nsat20, nsat16;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane(input int k);
        if (!enable[k]) return 0;
        if (k == 0) return longint'(data_i);
        return longint'(mchain[k-1]);
    endfunction

    task automatic fold(input int accw, output longint s, output bit sr);
        longint mx, mn, acc, t;
        mx  = (longint'(1) <<< (accw-1)) - 1;
        mn  = -mx - 1;
        acc = 0;
        sr  = 1'b0;
        foreach (prods[i]) begin
            t = acc + prods[i];
            if (t > mx) begin t = mx; sr = 1'b1; end
            if (t < mn) begin t = mn; sr = 1'b1; end
            acc = t;
        end
        s = acc;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin mchain[k] = 0; mw[k] = 0; end
        running = 0; pend = 0; mlen = 0; prods.delete();
        msum20 = 0; msum16 = 0; msat20 = 0; msat16 = 0;
    endtask

    task automatic step();
        longint s;
        bit busy_now, exp_sv;
        #1;
        s = 0;
        for (int k = 0; k < NP; k++) begin
            chk("tap_o", $signed(tap_a[k*DW +: DW]), lane(k));
            s += lane(k) * mw[k];
        end
        busy_now = running || pend;
        exp_sv = 1'b0;
        if (pend) begin
            exp_sv = 1'b1;
            pend = 0;
            msum20 = nsum20; msat20 = nsat20;
            msum16 = nsum16; msat16 = nsat16;
        end
        if (running && valid) begin
            prods.push_back(s);
            if (prods.size() == mlen) begin
                fold(20, nsum20, nsat20);
                fold(16, nsum16, nsat16);
                running = 0;
                pend = 1;
            end
        end else if (!busy_now && start) begin
            running = 1;
            mlen = (acc_len == 0) ? 1 : int'(acc_len);
            prods.delete();
        end
        if (valid) begin
            for (int k = NP-1; k > 0; k--) mchain[k] = mchain[k-1];
            mchain[0] = int'(data_i);
        end
        if (w_load && !busy_now) begin
            for (int k = NP-1; k > 0; k--) mw[k] = mw[k-1];
            mw[0] = int'(w_data);
        end
        @(posedge clk);
        #1;
        chk("data_o", data_a, longint'(mchain[NP-1]));
        chk("busy", busy_a, running || pend);
        chk("sum_valid", sv_a, exp_sv);
        chk("sum_o", sum_a, msum20);
        chk("sat", sat_a, msat20);
        chk("busy16", busy_b, running || pend);
        chk("sum_valid16", sv_b, exp_sv);
        chk("sum_o16", sum_b, msum16);
        chk("sat16", sat_b, msat16);
    endtask

    task automatic cyc(input bit v, input int d, input bit [NP-1:0] en, input bit st,
                       input int len, input bit wl, input int wd);
        valid = v; data_i = DW'(d); enable = en; start = st;
        acc_len = LW'(len); w_load = wl; w_data = DW'(wd);
        step();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_data_o", data_a, 0);
        chk("rst_sum_o", sum_a, 0);
        chk("rst_sum_valid", sv_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_sat", sat_a, 0);
        valid = 0; start = 0; w_load = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_data_o", data_a, 0);
        chk("reset_sum_o", sum_a, 0);
        chk("reset_busy", busy_a, 0);

        // chain shifting and hold
        cyc(1, 5, 3'b111, 0, 0, 0, 0);
        cyc(1, -3, 3'b111, 0, 0, 0, 0);
        cyc(1, 7, 3'b111, 0, 0, 0, 0);
        chk("chain_data_o", data_a, 5);
        for (int i = 0; i < 4; i++) cyc(0, 0, 3'b111, 0, 0, 0, 0);
        chk("chain_hold", data_a, 5);

        // combinational tap gating
        cyc(1, 5, 3'b000, 0, 0, 0, 0);
        data_i = 8'sd9; enable = 3'b010;
        #1;
        chk("tap_010_l0", $signed(tap_a[0 +: DW]), 0);
        chk("tap_010_l1", $signed(tap_a[DW +: DW]), 5);
        chk("tap_010_l2", $signed(tap_a[2*DW +: DW]), 0);
        enable = 3'b001;
        #1;
        chk("tap_001_l0", $signed(tap_a[0 +: DW]), 9);
        chk("tap_001_l1", $signed(tap_a[DW +: DW]), 0);
        step();

        // basic two-beat job
        cyc(0, 0, 3'b111, 0, 0, 1, 3);
        cyc(0, 0, 3'b111, 0, 0, 1, 2);
        cyc(0, 0, 3'b111, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 3'b111, 0, 0, 0, 0);
        cyc(0, 0, 3'b111, 1, 2, 0, 0);
        cyc(1, 4, 3'b111, 0, 0, 0, 0);
        cyc(1, 2, 3'b111, 0, 0, 0, 0);
        cyc(0, 0, 3'b111, 0, 0, 0, 0);
        chk("job_sum_14", sum_a, 14);
        chk("job_sv", sv_a, 1);
        chk("job_sat0", sat_a, 0);
        cyc(0, 0, 3'b111, 0, 0, 0, 0);
        chk("job_sv_one_cycle", sv_a, 0);

        // negative saturation over 255 beats
        for (int i = 0; i < 3; i++) cyc(0, 0, 3'b111, 0, 0, 1, 127);
        for (int i = 0; i < 3; i++) cyc(1, -128, 3'b111, 0, 0, 0, 0);
        cyc(1, -128, 3'b111, 1, 255, 0, 0);
        for (int i = 0; i < 255; i++) cyc(1, -128, 3'b111, 0, 0, 0, 0);
        cyc(0, 0, 3'b111, 0, 0, 0, 0);
        chk("sat16_sum", sum_b, -32768);
        chk("sat16_flag", sat_b, 1);
        chk("sat20_sum", sum_a, -524288);
        chk("sat20_flag", sat_a, 1);
        cyc(0, 0, 3'b111, 1, 1, 0, 0);
        cyc(1, 1, 3'b111, 0, 0, 0, 0);
        cyc(0, 0, 3'b111, 0, 0, 0, 0);
        chk("nosat16_flag", sat_b, 0);

        // start and w_load ignored while busy
        cyc(0, 0, 3'b111, 1, 3, 0, 0);
        cyc(1, 10, 3'b111, 0, 0, 0, 0);
        cyc(1, 20, 3'b111, 1, 1, 1, 50);
        cyc(0, 0, 3'b111, 1, 1, 1, 60);
        cyc(1, -30, 3'b111, 0, 0, 0, 0);
        cyc(0, 0, 3'b111, 0, 0, 1, 70);
        cyc(0, 0, 3'b111, 0, 0, 0, 0);

        // reset mid-job aborts without a pulse
        cyc(0, 0, 3'b111, 1, 5, 0, 0);
        cyc(1, 3, 3'b111, 0, 0, 0, 0);
        cyc(1, 4, 3'b111, 0, 0, 0, 0);
        async_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 3'b111, 0, 0, 0, 0);
        chk("abort_no_sv", sv_a, 0);

        // acc_len = 0 runs one beat
        cyc(0, 0, 3'b111, 0, 0, 1, 6);
        cyc(0, 0, 3'b111, 1, 0, 0, 0);
        cyc(1, 7, 3'b111, 0, 0, 0, 0);
        cyc(0, 0, 3'b111, 0, 0, 0, 0);
        chk("len0_sv", sv_a, 1);
        chk("len0_sum", sum_a, 42);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom % 4) != 0, int'($urandom_range(0, 255)) - 128, 3'($urandom),
                ($urandom % 6) == 0, int'($urandom % 7), ($urandom % 5) == 0,
                int'($urandom_range(0, 255)) - 128);
        end
        for (int i = 0; i < 8; i++) cyc(1, 1, 3'b111, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
